// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: B-type compare, JAL/JALR/B targets, registered fetch redirect
// and FSM-held front-end flush. Optional 2-bit BHT enabled by defining BRANCH_BHT_EN.
module branch_resolve_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_STAGES = 2,
  parameter int unsigned BHT_ENTRIES  = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            ex_valid_i,
  input  logic            stall_i,
  input  logic [6:0]      ex_opcode_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            fetch_pred_taken_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [XLEN-1:0] link_pc_o,
  output logic            flush_o,
  output logic            illegal_br_o
);

  localparam int unsigned CNT_W = 3;
  localparam logic [6:0]  OP_BR   = 7'b1100011;
  localparam logic [6:0]  OP_JALR = 7'b1100111;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]   link_pc_q, link_pc_d;
  logic              illegal_q, illegal_d;

  logic              is_br, is_jal, is_jalr, accept;
  logic              br_taken, br_illegal, pred_eff, redirect_req;
  logic [XLEN-1:0]   sum_pc_imm, sum_rs1_imm, jalr_tgt, pc_plus4, target;

  assign is_br   = (ex_opcode_i == OP_BR);
  assign is_jal  = (ex_opcode_i == OP_JAL);
  assign is_jalr = (ex_opcode_i == OP_JALR);
  assign accept  = ex_valid_i && !stall_i && (state_q == S_IDLE);

  assign sum_pc_imm  = ex_pc_i + ex_imm_i;
  assign sum_rs1_imm = ex_rs1_i + ex_imm_i;
  assign jalr_tgt    = {sum_rs1_imm[XLEN-1:1], 1'b0};
  assign pc_plus4    = ex_pc_i + XLEN'(4);

  // B-type condition evaluation; funct3 010/011 are reserved encodings
  always_comb begin
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    case (ex_funct3_i)
      3'b000:  br_taken = (ex_rs1_i == ex_rs2_i);
      3'b001:  br_taken = (ex_rs1_i != ex_rs2_i);
      3'b100:  br_taken = ($signed(ex_rs1_i) <  $signed(ex_rs2_i));
      3'b101:  br_taken = ($signed(ex_rs1_i) >= $signed(ex_rs2_i));
      3'b110:  br_taken = (ex_rs1_i <  ex_rs2_i);
      3'b111:  br_taken = (ex_rs1_i >= ex_rs2_i);
      default: br_illegal = 1'b1;
    endcase
  end

  assign redirect_req = is_jal || is_jalr || (is_br && !br_illegal && (br_taken != pred_eff));

  always_comb begin
    target = pc_plus4;
    if (is_jal)                   target = sum_pc_imm;
    else if (is_jalr)             target = jalr_tgt;
    else if (br_taken)            target = sum_pc_imm;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    link_pc_d        = link_pc_q;
    illegal_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          illegal_d = is_br && br_illegal;
          if (redirect_req) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
            link_pc_d        = pc_plus4;
            state_d          = S_FLUSH;
            cnt_d            = CNT_W'(FLUSH_STAGES);
          end
        end
      end
      S_FLUSH: begin
        // flush lasts exactly FLUSH_STAGES non-stalled cycles
        if (!stall_i) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      link_pc_q        <= '0;
      illegal_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      link_pc_q        <= link_pc_d;
      illegal_q        <= illegal_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign link_pc_o        = link_pc_q;
  assign illegal_br_o     = illegal_q;
  assign flush_o          = (state_q == S_FLUSH);

`ifdef BRANCH_BHT_EN
  localparam int unsigned IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] upd_idx, rd_idx;
  logic             bht_we;
  logic             unused_fetch_bits;

  assign upd_idx  = ex_pc_i[IDX_W+1:2];
  assign rd_idx   = fetch_pc_i[IDX_W+1:2];
  assign bht_we   = accept && is_br && !br_illegal;
  assign pred_eff = ex_pred_taken_i;
  assign unused_fetch_bits = ^{fetch_pc_i[XLEN-1:IDX_W+2], fetch_pc_i[1:0]};

  // Saturating 2-bit counters; a same-cycle read sees the pre-update value
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      if (br_taken && (bht_q[upd_idx] != 2'b11))       bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
      else if (!br_taken && (bht_q[upd_idx] != 2'b00)) bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
    end
  end

  assign fetch_pred_taken_o = bht_q[rd_idx][1];
`else
  logic unused_no_bht;

  assign pred_eff           = 1'b0;
  assign fetch_pred_taken_o = 1'b0;
  assign unused_no_bht      = ^{ex_pred_taken_i, fetch_pc_i};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed table, hand sequences for flush/stall/reset,
// and randomized instructions against a behavioural model (BHT model active with BRANCH_BHT_EN).
module tb_branch_resolve_unit;

  localparam int unsigned FLUSH_STAGES = 2;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        pred;
    logic        e_redir;
    logic [31:0] e_rpc, e_lpc;
    logic        e_ill;
    logic        e_upd;
    logic        e_tk;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, stall = 1'b0, ex_pred = 1'b0;
  logic [6:0]  ex_opcode = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_pc = '0, ex_rs1 = '0, ex_rs2 = '0, ex_imm = '0, fetch_pc = '0;
  logic        fetch_pred_o, redirect_valid_o, flush_o, illegal_br_o;
  logic [31:0] redirect_pc_o, link_pc_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rpc = '0, exp_lpc = '0;
  int bhtm [16];

  branch_resolve_unit #(.XLEN(32), .FLUSH_STAGES(FLUSH_STAGES), .BHT_ENTRIES(16)) dut (
    .clk_i(clk), .reset_i(reset), .ex_valid_i(ex_valid), .stall_i(stall),
    .ex_opcode_i(ex_opcode), .ex_funct3_i(ex_funct3), .ex_pc_i(ex_pc),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_imm_i(ex_imm),
    .ex_pred_taken_i(ex_pred), .fetch_pc_i(fetch_pc),
    .fetch_pred_taken_o(fetch_pred_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .link_pc_o(link_pc_o),
    .flush_o(flush_o), .illegal_br_o(illegal_br_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference behaviour derived from the ISA rules, not from the RTL structure
  function automatic vec_t model(input vec_t v);
    logic pe;
    logic tk;
`ifdef BRANCH_BHT_EN
    pe = v.pred;
`else
    pe = 1'b0;
`endif
    tk = 1'b0;
    v.e_redir = 1'b0; v.e_ill = 1'b0; v.e_upd = 1'b0; v.e_tk = 1'b0;
    v.e_rpc = '0;     v.e_lpc = v.pc + 32'd4;
    if (v.op == OP_JAL) begin
      v.e_redir = 1'b1; v.e_rpc = v.pc + v.imm;
    end else if (v.op == OP_JALR) begin
      v.e_redir = 1'b1; v.e_rpc = (v.rs1 + v.imm) & 32'hFFFF_FFFE;
    end else if (v.op == OP_BR) begin
      case (v.f3)
        3'd0: tk = (v.rs1 == v.rs2);
        3'd1: tk = (v.rs1 != v.rs2);
        3'd4: tk = ($signed(v.rs1) <  $signed(v.rs2));
        3'd5: tk = ($signed(v.rs1) >= $signed(v.rs2));
        3'd6: tk = (v.rs1 <  v.rs2);
        3'd7: tk = (v.rs1 >= v.rs2);
        default: v.e_ill = 1'b1;
      endcase
      if (!v.e_ill) begin
        v.e_upd = 1'b1; v.e_tk = tk;
        if (tk != pe) begin
          v.e_redir = 1'b1;
          v.e_rpc   = tk ? v.pc + v.imm : v.pc + 32'd4;
        end
      end
    end
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ex_opcode = v.op; ex_funct3 = v.f3; ex_pc = v.pc;
    ex_rs1 = v.rs1;   ex_rs2 = v.rs2;   ex_imm = v.imm; ex_pred = v.pred;
  endtask

  task automatic model_reset();
    exp_rpc = '0; exp_lpc = '0;
    for (int i = 0; i < 16; i++) bhtm[i] = 1;
  endtask

  // Issue one accepted instruction in IDLE and check result, pulse widths and flush length
  task automatic issue(input string tag, input vec_t v);
    int n;
    drive(v);
    ex_valid = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk({tag, ".redir"}, 32'(redirect_valid_o), 32'(v.e_redir));
    chk({tag, ".ill"},   32'(illegal_br_o),     32'(v.e_ill));
    if (v.e_redir) begin
      exp_rpc = v.e_rpc; exp_lpc = v.e_lpc;
    end
    chk({tag, ".rpc"}, redirect_pc_o, exp_rpc);
    chk({tag, ".lpc"}, link_pc_o,     exp_lpc);
    if (v.e_upd) begin
      if (v.e_tk && bhtm[v.pc[5:2]] < 3)  bhtm[v.pc[5:2]]++;
      if (!v.e_tk && bhtm[v.pc[5:2]] > 0) bhtm[v.pc[5:2]]--;
    end
    n = 0;
    while (flush_o && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk({tag, ".flushlen"}, 32'(n), v.e_redir ? 32'(FLUSH_STAGES) : 32'd0);
    @(posedge clk); #1;
    chk({tag, ".pulse_end"}, 32'({redirect_valid_o, illegal_br_o, flush_o}), 32'd0);
`ifdef BRANCH_BHT_EN
    fetch_pc = v.pc; #1;
    chk({tag, ".bht"}, 32'(fetch_pred_o), 32'(bhtm[v.pc[5:2]] >= 2));
`endif
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                              input logic pred);
    vec_t v;
    v.op = op; v.f3 = f3; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pred = pred;
    v.e_redir = 1'b0; v.e_rpc = '0; v.e_lpc = '0; v.e_ill = 1'b0; v.e_upd = 1'b0; v.e_tk = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t tbl [12];
    vec_t v, m;
    int n, bad;

    // Directed vectors: expected redirect/targets written out by hand
    tbl[0]  = '{OP_BR,   3'd0, 32'h100,      32'd5,        32'd5, 32'h20,       1'b0, 1'b1, 32'h120,  32'h104,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{OP_BR,   3'd4, 32'h300,      32'hFFFFFFFF, 32'd1, 32'h40,       1'b0, 1'b1, 32'h340,  32'h304,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{OP_BR,   3'd6, 32'h300,      32'hFFFFFFFF, 32'd1, 32'h40,       1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b0};
    tbl[3]  = '{OP_JALR, 3'd0, 32'h200,      32'h1003,     32'd0, 32'h4,        1'b0, 1'b1, 32'h1006, 32'h204,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{OP_JAL,  3'd0, 32'h400,      32'd0,        32'd0, 32'hFFFFFF00, 1'b1, 1'b1, 32'h300,  32'h404,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{OP_BR,   3'd1, 32'h500,      32'd3,        32'd3, 32'h8,        1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b0};
    tbl[6]  = '{OP_BR,   3'd5, 32'h600,      32'h80000000, 32'd0, 32'h10,       1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b0};
    tbl[7]  = '{OP_BR,   3'd7, 32'h600,      32'h80000000, 32'd0, 32'h10,       1'b0, 1'b1, 32'h610,  32'h604,  1'b0, 1'b0, 1'b0};
    tbl[8]  = '{OP_BR,   3'd2, 32'h700,      32'd1,        32'd1, 32'h10,       1'b0, 1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0};
    tbl[9]  = '{OP_BR,   3'd3, 32'h700,      32'd1,        32'd2, 32'h10,       1'b0, 1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0};
    tbl[10] = '{OP_ALU,  3'd0, 32'h800,      32'd1,        32'd1, 32'h10,       1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b0};
    tbl[11] = '{OP_BR,   3'd1, 32'hFFFFFFFC, 32'd1,        32'd2, 32'h8,        1'b0, 1'b1, 32'h4,    32'h0,    1'b0, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.outs", 32'({redirect_valid_o, flush_o, illegal_br_o, fetch_pred_o}), 32'd0);
    chk("reset.rpc", redirect_pc_o, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      m = model(tbl[i]);
      v = tbl[i];
      v.e_upd = m.e_upd; v.e_tk = m.e_tk;
      issue($sformatf("tbl%0d", i), v);
    end

    // Stalled EX instruction in IDLE is not accepted
    drive(mk(OP_JAL, 3'd0, 32'h900, 32'd0, 32'd0, 32'h40, 1'b0));
    ex_valid = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; stall = 1'b0;
    chk("stall_idle.redir", 32'(redirect_valid_o), 32'd0);
    chk("stall_idle.flush", 32'(flush_o), 32'd0);
    chk("stall_idle.rpc", redirect_pc_o, exp_rpc);

    // JAL in FLUSH is ignored; 3 stall cycles stretch flush to 2+3 cycles
    drive(mk(OP_JAL, 3'd0, 32'h800, 32'd0, 32'd0, 32'h100, 1'b0));
    ex_valid = 1'b1;
    @(posedge clk); #1;
    chk("seqA.redir", 32'(redirect_valid_o), 32'd1);
    chk("seqA.rpc", redirect_pc_o, 32'h900);
    exp_rpc = 32'h900; exp_lpc = 32'h804;
    ex_imm = 32'h1000;
    n = 0; bad = 0;
    while (flush_o && n < 30) begin
      n++;
      stall = (n >= 2 && n <= 4);
      @(posedge clk); #1;
      if (redirect_valid_o || illegal_br_o) bad++;
    end
    ex_valid = 1'b0; stall = 1'b0;
    chk("seqA.flushlen", 32'(n), 32'(FLUSH_STAGES + 3));
    chk("seqA.ignored", 32'(bad), 32'd0);
    chk("seqA.rpc_hold", redirect_pc_o, 32'h900);
    @(posedge clk); #1;
    chk("seqA.after", 32'({redirect_valid_o, flush_o}), 32'd0);

    // Randomized instructions against the model
    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [6:0] op;
      sel = $urandom_range(0, 9);
      op = (sel <= 5 || sel == 9) ? OP_BR : (sel == 6) ? OP_JAL : (sel == 7) ? OP_JALR : OP_ALU;
      v = mk(op, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
             ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)),
             ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)),
             $urandom, 1'($urandom_range(0, 1)));
      if (sel == 9) v.rs2 = v.rs1;
      issue($sformatf("rnd%0d", i), model(v));
    end

    // Asynchronous reset in the middle of a flush
    drive(mk(OP_JAL, 3'd0, 32'h1000, 32'd0, 32'd0, 32'h80, 1'b0));
    ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rst_mid.flush_before", 32'(flush_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.outs", 32'({redirect_valid_o, flush_o, illegal_br_o, fetch_pred_o}), 32'd0);
    chk("rst_mid.rpc", redirect_pc_o, 32'd0);
    chk("rst_mid.lpc", link_pc_o, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.after", 32'({redirect_valid_o, flush_o}), 32'd0);

`ifdef BRANCH_BHT_EN
    // Taken beq trains the entry for 0x40; later mispredicted not-taken redirects to pc+4
    fetch_pc = 32'h40; #1;
    chk("bht.init", 32'(fetch_pred_o), 32'd0);
    issue("bht.taken", model(mk(OP_BR, 3'd0, 32'h40, 32'd7, 32'd7, 32'h10, 1'b0)));
    fetch_pc = 32'h40; #1;
    chk("bht.trained", 32'(fetch_pred_o), 32'd1);
    issue("bht.nt", model(mk(OP_BR, 3'd0, 32'h40, 32'd7, 32'd8, 32'h10, 1'b1)));
    chk("bht.nt_rpc", redirect_pc_o, 32'h44);
`else
    fetch_pc = 32'h40; #1;
    chk("nobht.pred", 32'(fetch_pred_o), 32'd0);
    issue("nobht.pred1_nt", model(mk(OP_BR, 3'd0, 32'h40, 32'd7, 32'd8, 32'h10, 1'b1)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
